trace_stream_serialiser: RTL and testbench

- Consumes packed trace_format records (instruction, instr_addr, mem_addr, mem_trans_time_start, mem_trans_time_end; 160 bits) from the trace generator.
- Buffers them in a small FIFO and emits each record as five 32-bit beats on an AXI4-Stream-style master (tdata/tvalid/tready/tlast) toward the trace DMA/host link.
- The input never back-pressures the core; records that arrive while the buffer is full are dropped.

---
 rtl/trace_stream_serialiser_pkg.sv | 47 ++++
 rtl/trace_stream_serialiser_fifo.sv | 88 ++++++++
 rtl/trace_stream_serialiser.sv | 178 +++++++++++++++++
 tb/tb_trace_stream_serialiser.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_stream_serialiser_pkg.sv
// -----------------------------------------------------------------------------
// gouram_datatypes
// Shared types for the trace path: the packed 160-bit trace record, the beat
// enumeration used to serialise it onto a 32-bit stream, the serialiser FSM
// state type and a helper that selects one 32-bit word of a record.
// No ports (package).
// -----------------------------------------------------------------------------
package gouram_datatypes;

  localparam int TDATA_WIDTH = 32;
  localparam int TRACE_BEATS = 5;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] instr_addr;
    logic [31:0] mem_addr;
    logic [31:0] mem_trans_time_start;
    logic [31:0] mem_trans_time_end;
  } trace_format;

  typedef enum logic [2:0] {
    BEAT_INSTR      = 3'd0,
    BEAT_INSTR_ADDR = 3'd1,
    BEAT_MEM_ADDR   = 3'd2,
    BEAT_TIME_START = 3'd3,
    BEAT_TIME_END   = 3'd4
  } trace_beat_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } ser_state_t;

  // Word of a record carried by a given beat; unreachable beat codes yield zero.
  function automatic logic [TDATA_WIDTH-1:0] trace_word(input trace_format rec,
                                                        input trace_beat_t beat);
    case (beat)
      BEAT_INSTR:      trace_word = rec.instruction;
      BEAT_INSTR_ADDR: trace_word = rec.instr_addr;
      BEAT_MEM_ADDR:   trace_word = rec.mem_addr;
      BEAT_TIME_START: trace_word = rec.mem_trans_time_start;
      BEAT_TIME_END:   trace_word = rec.mem_trans_time_end;
      default:         trace_word = {TDATA_WIDTH{1'b0}};
    endcase
  endfunction

endpackage

// File: rtl/trace_stream_serialiser_fifo.sv
// -----------------------------------------------------------------------------
// trace_record_fifo
// Small register-based FIFO of trace records. A push is accepted when the FIFO
// is not full, or when it is full but the head is popped in the same cycle.
// The head is read straight from storage, so a record written in cycle N is
// first visible in cycle N+1 (no fall-through).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   push, wr_data  write request and record
//   pop            remove head (ignored when empty)
//   head           current head record
//   occupancy      records held (log2(DEPTH)+1 bits)
//   full, empty    status (full is registered)
//   push_ok        the push in this cycle is accepted
// -----------------------------------------------------------------------------
module trace_record_fifo
  import gouram_datatypes::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  trace_format              wr_data,
  input  logic                     pop,
  output trace_format              head,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty,
  output logic                     push_ok
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  trace_format         mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [CW-1:0]       count_r;
  logic [CW-1:0]       count_next_s;
  logic                full_r;
  logic                pop_ok_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign pop_ok_s  = pop & ~empty;
  assign push_ok   = push & (~full_r | pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign occupancy = count_r;
  assign full      = full_r;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok, pop_ok_s})
      2'b10:   count_next_s = count_r + CW'(1);
      2'b01:   count_next_s = count_r - CW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and registered full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_C);
    end
  end

  // Record storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/trace_stream_serialiser.sv
// -----------------------------------------------------------------------------
// trace_stream_serialiser
// Buffers 160-bit trace records and emits each one as five 32-bit beats on an
// AXI4-Stream-style master. The input side never stalls: records arriving
// while the buffer is full are dropped and the sticky overflow flag is set.
// Optional macro GOURAM_TRACE_DROP_COUNT_EN adds a saturating drop counter
// (drop_count) and a clear input (drop_count_clr) that also clears overflow.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   trace_in            record (gouram_datatypes::trace_format)
//   trace_valid         one-cycle strobe per record
//   m_tdata/m_tvalid    output beat / valid
//   m_tready            downstream ready
//   m_tlast             final (5th) beat of a record
//   fifo_full           buffer holds FIFO_DEPTH records
//   overflow            at least one record dropped
//   drop_count          (macro only) number of dropped records, saturating
//   drop_count_clr      (macro only) zero drop_count and overflow
// -----------------------------------------------------------------------------
module trace_stream_serialiser
  import gouram_datatypes::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  trace_format            trace_in,
  input  logic                   trace_valid,
  output logic [TDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   fifo_full,
`ifdef GOURAM_TRACE_DROP_COUNT_EN
  output logic [31:0]            drop_count,
  input  logic                   drop_count_clr,
`endif
  output logic                   overflow
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ser_state_t    state_r;
  ser_state_t    state_next_s;
  logic [2:0]    beat_r;
  logic [2:0]    beat_next_s;
  trace_format   head_s;
  logic [CW-1:0] occupancy_s;
  logic [CW-1:0] occ_after_s;
  logic          fifo_empty_s;
  logic          push_ok_s;
  logic          handshake_s;
  logic          last_beat_s;
  logic          pop_s;
  logic          drop_s;
  logic          overflow_r;

  trace_record_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (trace_valid),
    .wr_data   (trace_in),
    .pop       (pop_s),
    .head      (head_s),
    .occupancy (occupancy_s),
    .full      (fifo_full),
    .empty     (fifo_empty_s),
    .push_ok   (push_ok_s)
  );

  // Outputs decode only state registers and storage, never the inputs.
  assign m_tvalid    = (state_r == ST_STREAM);
  assign last_beat_s = (beat_r == 3'(TRACE_BEATS - 1));
  assign m_tlast     = m_tvalid & last_beat_s;
  assign m_tdata     = m_tvalid ? trace_word(head_s, trace_beat_t'(beat_r))
                                : {TDATA_WIDTH{1'b0}};
  assign handshake_s = m_tvalid & m_tready;
  assign pop_s       = handshake_s & last_beat_s;
  assign drop_s      = trace_valid & ~push_ok_s;
  assign overflow    = overflow_r;

  // Occupancy once this cycle's push and pop have been applied.
  always_comb begin
    occ_after_s = occupancy_s;
    if (push_ok_s) begin
      occ_after_s = occ_after_s + CW'(1);
    end else begin
      occ_after_s = occ_after_s;
    end
    if (pop_s) begin
      occ_after_s = occ_after_s - CW'(1);
    end else begin
      occ_after_s = occ_after_s;
    end
  end

  // Serialiser next state. Entering STREAM on the push itself gives beat 0 in
  // the following cycle; staying in STREAM after a pop avoids a bubble.
  always_comb begin
    state_next_s = state_r;
    beat_next_s  = beat_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s || push_ok_s) begin
          state_next_s = ST_STREAM;
          beat_next_s  = 3'd0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (handshake_s && last_beat_s) begin
          beat_next_s  = 3'd0;
          state_next_s = (occ_after_s != {CW{1'b0}}) ? ST_STREAM : ST_IDLE;
        end else if (handshake_s) begin
          beat_next_s = beat_r + 3'd1;
        end else begin
          beat_next_s = beat_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        beat_next_s  = 3'd0;
      end
    endcase
  end

  // Serialiser state and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      beat_r  <= 3'd0;
    end else begin
      state_r <= state_next_s;
      beat_r  <= beat_next_s;
    end
  end

`ifdef GOURAM_TRACE_DROP_COUNT_EN
  logic [31:0] drop_count_r;
  assign drop_count = drop_count_r;

  // Drop tracking; a drop in the clear cycle counts as the first new drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 32'd0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_count_clr) begin
        drop_count_r <= 32'd1;
      end else if (drop_count_r != 32'hFFFF_FFFF) begin
        drop_count_r <= drop_count_r + 32'd1;
      end else begin
        drop_count_r <= drop_count_r;
      end
    end else if (drop_count_clr) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 32'd0;
    end else begin
      overflow_r   <= overflow_r;
      drop_count_r <= drop_count_r;
    end
  end
`else
  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | drop_s;
    end
  end
`endif

endmodule

// File: tb/tb_trace_stream_serialiser.sv
// -----------------------------------------------------------------------------
// tb_trace_stream_serialiser
// Directed bench: a per-cycle vector table for single-record and stalled
// streaming, then hand-written sequences for back-to-back records, overflow,
// optional drop counting (GOURAM_TRACE_DROP_COUNT_EN) and reset mid-record.
// -----------------------------------------------------------------------------
module tb_trace_stream_serialiser;
  import gouram_datatypes::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  trace_format trace_in = '0;
  logic        trace_valid = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        fifo_full;
  logic        overflow;
`ifdef GOURAM_TRACE_DROP_COUNT_EN
  logic [31:0] drop_count;
  logic        drop_count_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  trace_stream_serialiser #(.FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trace_in       (trace_in),
    .trace_valid    (trace_valid),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tlast        (m_tlast),
    .fifo_full      (fifo_full),
`ifdef GOURAM_TRACE_DROP_COUNT_EN
    .drop_count     (drop_count),
    .drop_count_clr (drop_count_clr),
`endif
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        rdy;
    logic        e_tvalid;
    logic [31:0] e_tdata;
    logic        e_tlast;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Distinct word for record k, beat b.
  function automatic logic [31:0] w(input int k, input int b);
    w = (32'(k + 1) << 16) | 32'(b);
  endfunction

  function automatic trace_format mk(input int k);
    trace_format r;
    r.instruction          = w(k, 0);
    r.instr_addr           = w(k, 1);
    r.mem_addr             = w(k, 2);
    r.mem_trans_time_start = w(k, 3);
    r.mem_trans_time_end   = w(k, 4);
    return r;
  endfunction

  trace_format rec_a;
  int hs_cnt, last_cnt, j;
  logic [7:0] rdy_pat;

  initial begin
    rec_a.instruction          = 32'h00A0_0093;
    rec_a.instr_addr           = 32'h0000_0080;
    rec_a.mem_addr             = 32'h0000_1000;
    rec_a.mem_trans_time_start = 32'h0000_0005;
    rec_a.mem_trans_time_end   = 32'h0000_0009;

    // Single record, tready=1: beats in cycles 1..5.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h00A0_0093, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0080, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0005, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0009, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0};
    // Same record with tready pattern 1,0,0,1,...: each beat held while stalled.
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h00A0_0093, 1'b0};
    rdy_pat = 8'b0;
    for (int i = 0; i < 12; i++) begin
      logic [31:0] d;
      case (i / 3)
        0: d = 32'h0000_0080;
        1: d = 32'h0000_1000;
        2: d = 32'h0000_0005;
        default: d = 32'h0000_0009;
      endcase
      vecs[9 + i] = '{1'b0, (i % 3 == 2), 1'b1, d, (i / 3 == 3)};
    end
    vecs[21] = '{1'b0, 1'b1, 1'b0, 32'h0, 1'b0};

    // Reset state.
    #2;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'h0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
`ifdef GOURAM_TRACE_DROP_COUNT_EN
    chk("rst_drop_count", drop_count, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors.
    hs_cnt = 0;
    last_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      trace_valid = vecs[i].vld;
      trace_in    = rec_a;
      m_tready    = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_tvalid", i), 32'(m_tvalid), 32'(vecs[i].e_tvalid));
      chk($sformatf("vec%0d_tdata", i), m_tdata, vecs[i].e_tdata);
      chk($sformatf("vec%0d_tlast", i), 32'(m_tlast), 32'(vecs[i].e_tlast));
      chk($sformatf("vec%0d_full", i), 32'(fifo_full), 32'd0);
      if (m_tvalid && m_tready) hs_cnt++;
      if (m_tvalid && m_tready && m_tlast) last_cnt++;
    end
    chk("table_handshakes", 32'(hs_cnt), 32'd10);
    chk("table_tlast_hs", 32'(last_cnt), 32'd2);

    // Four records back-to-back, tready=1: 20 contiguous beats.
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      trace_valid = (i < 4);
      trace_in    = mk(i);
      m_tready    = 1'b1;
      #1;
      if (i >= 1) begin
        chk($sformatf("b2b%0d_tvalid", i), 32'(m_tvalid), 32'd1);
        chk($sformatf("b2b%0d_tdata", i), m_tdata, w((i - 1) / 5, (i - 1) % 5));
        chk($sformatf("b2b%0d_tlast", i), 32'(m_tlast), 32'((i - 1) % 5 == 4));
      end
    end
    @(negedge clk);
    trace_valid = 1'b0;
    #1;
    chk("b2b_end_tvalid", 32'(m_tvalid), 32'd0);
    chk("b2b_no_overflow", 32'(overflow), 32'd0);

    // Overflow: tready=0, six pushes; records 4 and 5 dropped.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      trace_valid = 1'b1;
      trace_in    = mk(30 + i);
      m_tready    = 1'b0;
      #1;
      if (i == 4) chk("ovf_full_after_4th", 32'(fifo_full), 32'd1);
      if (i == 4) chk("ovf_not_yet", 32'(overflow), 32'd0);
      if (i == 5) chk("ovf_set", 32'(overflow), 32'd1);
      if (i >= 1) chk($sformatf("ovf%0d_held", i), m_tdata, w(30, 0));
    end
    @(negedge clk);
    trace_valid = 1'b0;
    #1;
    chk("ovf_full_held", 32'(fifo_full), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
`ifdef GOURAM_TRACE_DROP_COUNT_EN
    chk("drop_count_2", drop_count, 32'd2);
    drop_count_clr = 1'b1;
    @(negedge clk);
    #1;
    chk("clr_drop_count", drop_count, 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    trace_valid = 1'b1;
    trace_in    = mk(99);
    @(negedge clk);
    trace_valid    = 1'b0;
    drop_count_clr = 1'b0;
    #1;
    chk("clr_and_drop_count", drop_count, 32'd1);
    chk("clr_and_drop_overflow", 32'(overflow), 32'd1);
`endif
    j = 0;
    for (int c = 0; c < 40 && j < 20; c++) begin
      @(negedge clk);
      m_tready = 1'b1;
      #1;
      if (m_tvalid) begin
        chk($sformatf("drain%0d_tdata", j), m_tdata, w(30 + j / 5, j % 5));
        chk($sformatf("drain%0d_tlast", j), 32'(m_tlast), 32'(j % 5 == 4));
        j++;
      end
    end
    chk("drain_beats", 32'(j), 32'd20);
    @(negedge clk);
    #1;
    chk("drain_end_tvalid", 32'(m_tvalid), 32'd0);
    chk("drain_full_clear", 32'(fifo_full), 32'd0);
    chk("overflow_still_set", 32'(overflow), 32'd1);

    // Reset during beat 2 of a record with two more buffered.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      trace_valid = (i < 3);
      trace_in    = mk(40 + i);
      m_tready    = 1'b1;
    end
    @(negedge clk);
    trace_valid = 1'b0;
    #1;
    chk("mid_beat2_tdata", m_tdata, w(40, 2));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_tdata", m_tdata, 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_full", 32'(fifo_full), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_rst%0d_tvalid", i), 32'(m_tvalid), 32'd0);
    end
    @(negedge clk);
    trace_valid = 1'b1;
    trace_in    = mk(50);
    @(negedge clk);
    trace_valid = 1'b0;
    #1;
    chk("post_rst_new_tvalid", 32'(m_tvalid), 32'd1);
    chk("post_rst_new_tdata", m_tdata, w(50, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
